// File: rtl/m26_frame_checker.sv
// Mimosa26 frame checker: drains the receiver FWFT FIFO, tracks frame structure,
// stamps a status code into bits [19:18] of every forwarded word and counts frame events.
module m26_frame_checker #(
  parameter int unsigned MAX_LEN = 570,
  parameter logic [15:0] TRAILER = 16'hAA50,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             BUS_CLK,
  input  logic             RST,
  input  logic             IN_EMPTY,
  output logic             IN_READ,
  input  logic [31:0]      IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_DATA,
  output logic [CNT_W-1:0] FRAME_CNT,
  output logic [7:0]       ERR_CNT,
  output logic [CNT_W-1:0] DROP_CNT,
  output logic             LOST_SEEN
);

  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StTrl} state_e;

  state_e           state_q, state_d;
  logic [1:0]       pos_q, pos_d;
  logic [15:0]      rem_q, rem_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [7:0]       err_q, err_d;
  logic             lost_q, lost_d;

  logic             rd, fwd, err_inc, start;
  logic [1:0]       code;
  logic [15:0]      payload;
  logic [31:0]      fwd_word;

  assign start   = IN_DATA[16];
  assign payload = IN_DATA[15:0];
  assign rd      = !IN_EMPTY && (!valid_q || OUT_READY);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    rem_d   = rem_q;
    fwd     = 1'b0;
    code    = 2'b00;
    err_inc = 1'b0;
    frame_d = frame_q;
    drop_d  = drop_q;
    lost_d  = lost_q | (rd & IN_DATA[17]);

    if (rd) begin
      if (state_q != StIdle && start) begin
        // A new start truncates whatever frame was open; restart header tracking.
        fwd     = 1'b1;
        code    = 2'b11;
        err_inc = 1'b1;
        state_d = StHdr;
        pos_d   = 2'd1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              fwd     = 1'b1;
              state_d = StHdr;
              pos_d   = 2'd1;
            end else begin
              drop_d = drop_q + CNT_W'(1);
            end
          end
          StHdr: begin
            fwd = 1'b1;
            if (pos_q != 2'd3) begin
              pos_d = pos_q + 2'd1;
            end else if (payload > MaxLen) begin
              code    = 2'b10;
              err_inc = 1'b1;
              state_d = StIdle;
            end else if (payload == 16'd0) begin
              state_d = StTrl;
            end else begin
              rem_d   = payload;
              state_d = StData;
            end
          end
          StData: begin
            fwd   = 1'b1;
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = StTrl;
          end
          StTrl: begin
            fwd     = 1'b1;
            state_d = StIdle;
            if (payload == TRAILER) begin
              code    = 2'b01;
              frame_d = frame_q + CNT_W'(1);
            end else begin
              code    = 2'b10;
              err_inc = 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

    fwd_word        = IN_DATA;
    fwd_word[19:18] = code;
    data_d          = fwd ? fwd_word : data_q;

    if (fwd) begin
      valid_d = 1'b1;
    end else if (valid_q && OUT_READY) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_q <= StIdle;
      pos_q   <= 2'd0;
      rem_q   <= 16'd0;
      valid_q <= 1'b0;
      data_q  <= 32'd0;
      frame_q <= '0;
      drop_q  <= '0;
      err_q   <= 8'd0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign IN_READ   = rd;
  assign OUT_VALID = valid_q;
  assign OUT_DATA  = data_q;
  assign FRAME_CNT = frame_q;
  assign ERR_CNT   = err_q;
  assign DROP_CNT  = drop_q;
  assign LOST_SEEN = lost_q;

endmodule

// File: tb/tb_m26_frame_checker.sv
// Bench for m26_frame_checker: FWFT source queue, output sink with random back-pressure,
// hand-written frame vectors and a frame-offset reference model for random traffic.
module tb_m26_frame_checker;

  logic        BUS_CLK = 1'b0;
  logic        RST, IN_EMPTY, IN_READ, OUT_VALID, OUT_READY, LOST_SEEN;
  logic [31:0] IN_DATA, OUT_DATA;
  logic [15:0] FRAME_CNT, DROP_CNT;
  logic [7:0]  ERR_CNT;

  always #5 BUS_CLK = ~BUS_CLK;

  m26_frame_checker dut (
    .BUS_CLK   (BUS_CLK),
    .RST       (RST),
    .IN_EMPTY  (IN_EMPTY),
    .IN_READ   (IN_READ),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .FRAME_CNT (FRAME_CNT),
    .ERR_CNT   (ERR_CNT),
    .DROP_CNT  (DROP_CNT),
    .LOST_SEEN (LOST_SEEN)
  );

  typedef struct {
    int          grp;
    logic [31:0] din;
    bit          fwd;
    logic [1:0]  code;
  } vec_t;

  typedef struct {
    int frame;
    int err;
    int drop;
  } cnt_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] inq[$];
  logic [31:0] gotq[$];
  logic [31:0] expq[$];
  vec_t        vt[$];
  cnt_t        ge[4];
  int          ready_pct = 100;
  int          gap_pct = 0;
  bit          stall = 0;
  logic [31:0] stall_data;

  // Reference model: offset of the next word within the open frame (-1 = no frame).
  int m_off = -1;
  int m_len = 0;
  int m_frame = 0;
  int m_err = 0;
  int m_drop = 0;
  bit m_lost = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_word(input logic [31:0] w);
    logic [1:0] c;
    bit         emit;
    c    = 2'b00;
    emit = 1'b1;
    if (w[17]) m_lost = 1'b1;
    if (m_off < 0) begin
      if (w[16]) m_off = 1;
      else begin
        emit   = 1'b0;
        m_drop = (m_drop + 1) % 65536;
      end
    end else if (w[16]) begin
      c = 2'b11;
      if (m_err < 255) m_err++;
      m_off = 1;
    end else if (m_off < 3) begin
      m_off++;
    end else if (m_off == 3) begin
      m_len = int'(w[15:0]);
      if (m_len > 570) begin
        c = 2'b10;
        if (m_err < 255) m_err++;
        m_off = -1;
      end else m_off = 4;
    end else if (m_off < 4 + m_len) begin
      m_off++;
    end else begin
      if (w[15:0] == 16'hAA50) begin
        c       = 2'b01;
        m_frame = (m_frame + 1) % 65536;
      end else begin
        c = 2'b10;
        if (m_err < 255) m_err++;
      end
      m_off = -1;
    end
    if (emit) expq.push_back({w[31:20], c, w[17:0]});
  endfunction

  function automatic void send(input logic [31:0] w);
    inq.push_back(w);
    model_word(w);
  endfunction

  function automatic logic [31:0] rword(input bit s, input bit l, input logic [15:0] p);
    logic [31:0] r;
    r = $urandom;
    return {r[31:20], 2'b00, l, s, p};
  endfunction

  function automatic void add(input int g, input bit s, input logic [15:0] p, input bit f,
                              input logic [1:0] c);
    vec_t v;
    v.grp  = g;
    v.din  = {8'hE7, 4'h2, 2'b00, 1'b0, s, p};
    v.fwd  = f;
    v.code = c;
    vt.push_back(v);
  endfunction

  task automatic cycle();
    bit rd;
    @(negedge BUS_CLK);
    IN_EMPTY  = (inq.size() == 0) || ($urandom_range(99) < gap_pct);
    IN_DATA   = (inq.size() != 0) ? inq[0] : 32'h0;
    OUT_READY = ($urandom_range(99) < ready_pct);
    #1;
    check("in_read", IN_READ, !IN_EMPTY && (!OUT_VALID || OUT_READY));
    if (stall) check("out_hold", {OUT_VALID, OUT_DATA}, {1'b1, stall_data});
    stall      = OUT_VALID && !OUT_READY;
    stall_data = OUT_DATA;
    rd         = IN_READ;
    if (OUT_VALID && OUT_READY) gotq.push_back(OUT_DATA);
    @(posedge BUS_CLK);
    if (rd) void'(inq.pop_front());
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((inq.size() != 0 || OUT_VALID) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (inq.size() != 0 || OUT_VALID) begin
      failures++;
      $display("FAIL drain_timeout: %0d words left, OUT_VALID=%0b after %0d cycles",
               inq.size(), OUT_VALID, n);
    end
  endtask

  task automatic compare_out(input string tag);
    int n;
    check({tag, "_count"}, gotq.size(), expq.size());
    n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, gotq[i], expq[i]);
    gotq.delete();
    expq.delete();
  endtask

  task automatic model_counters(input string tag);
    check({tag, "_frame"}, FRAME_CNT, m_frame);
    check({tag, "_err"}, ERR_CNT, m_err);
    check({tag, "_drop"}, DROP_CNT, m_drop);
    check({tag, "_lost"}, LOST_SEEN, m_lost);
  endtask

  task automatic do_reset();
    @(negedge BUS_CLK);
    RST       = 1'b1;
    IN_EMPTY  = 1'b1;
    OUT_READY = 1'b0;
    @(posedge BUS_CLK);
    #1;
    RST = 1'b0;
    inq.delete();
    gotq.delete();
    expq.delete();
    stall   = 0;
    m_off   = -1;
    m_len   = 0;
    m_frame = 0;
    m_err   = 0;
    m_drop  = 0;
    m_lost  = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, OUT_VALID, 1'b0);
    check({tag, "_frame"}, FRAME_CNT, 16'd0);
    check({tag, "_err"}, ERR_CNT, 8'd0);
    check({tag, "_drop"}, DROP_CNT, 16'd0);
    check({tag, "_lost"}, LOST_SEEN, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    int          len;
    RST       = 1'b1;
    IN_EMPTY  = 1'b1;
    IN_DATA   = 32'h0;
    OUT_READY = 1'b0;

    // Hand-computed vectors: good frame, strays + LEN=0, LEN=571, bad trailer, truncation.
    add(0, 1, 16'h5A00, 1, 2'b00); add(0, 0, 16'h0001, 1, 2'b00); add(0, 0, 16'h0000, 1, 2'b00);
    add(0, 0, 16'h0002, 1, 2'b00); add(0, 0, 16'h1111, 1, 2'b00); add(0, 0, 16'h2222, 1, 2'b00);
    add(0, 0, 16'hAA50, 1, 2'b01);
    add(1, 0, 16'h1234, 0, 2'b00); add(1, 0, 16'hAA50, 0, 2'b00); add(1, 0, 16'h0000, 0, 2'b00);
    add(1, 1, 16'h0B00, 1, 2'b00); add(1, 0, 16'h0007, 1, 2'b00); add(1, 0, 16'h0000, 1, 2'b00);
    add(1, 0, 16'h0000, 1, 2'b00); add(1, 0, 16'hAA50, 1, 2'b01);
    add(2, 1, 16'h0000, 1, 2'b00); add(2, 0, 16'h0003, 1, 2'b00); add(2, 0, 16'h0000, 1, 2'b00);
    add(2, 0, 16'd571, 1, 2'b10);  add(2, 0, 16'h0005, 0, 2'b00); add(2, 0, 16'hAA50, 0, 2'b00);
    add(3, 1, 16'h0000, 1, 2'b00); add(3, 0, 16'h0004, 1, 2'b00); add(3, 0, 16'h0000, 1, 2'b00);
    add(3, 0, 16'h0001, 1, 2'b00); add(3, 0, 16'h3333, 1, 2'b00); add(3, 0, 16'hAA51, 1, 2'b10);
    add(3, 1, 16'h0000, 1, 2'b00); add(3, 0, 16'h0005, 1, 2'b00); add(3, 0, 16'h0000, 1, 2'b00);
    add(3, 0, 16'h0003, 1, 2'b00); add(3, 0, 16'h4444, 1, 2'b00); add(3, 1, 16'h0C00, 1, 2'b11);
    add(3, 0, 16'h0006, 1, 2'b00); add(3, 0, 16'h0000, 1, 2'b00); add(3, 0, 16'h0001, 1, 2'b00);
    add(3, 0, 16'h5555, 1, 2'b00); add(3, 0, 16'hAA50, 1, 2'b01);
    ge[0] = '{1, 0, 0};
    ge[1] = '{2, 0, 3};
    ge[2] = '{2, 1, 5};
    ge[3] = '{3, 3, 5};

    do_reset();
    check_reset("reset");
    check("reset_in_read", IN_READ, 1'b0);

    ready_pct = 70;
    gap_pct   = 10;
    for (int g = 0; g < 4; g++) begin
      foreach (vt[i]) begin
        if (vt[i].grp == g) begin
          inq.push_back(vt[i].din);
          if (vt[i].fwd) expq.push_back({vt[i].din[31:20], vt[i].code, vt[i].din[17:0]});
        end
      end
      drain(400);
      compare_out($sformatf("table%0d", g));
      check($sformatf("table%0d_frame", g), FRAME_CNT, ge[g].frame);
      check($sformatf("table%0d_err", g), ERR_CNT, ge[g].err);
      check($sformatf("table%0d_drop", g), DROP_CNT, ge[g].drop);
    end

    // Lost flag inside a frame is sticky; reset mid-frame drops the pending word.
    do_reset();
    ready_pct = 100;
    gap_pct   = 0;
    send(rword(1, 0, 16'h0100)); send(rword(0, 0, 16'h0001)); send(rword(0, 0, 16'h0000));
    send(rword(0, 0, 16'h0002)); send(rword(0, 1, 16'h0777)); send(rword(0, 0, 16'h0888));
    send(rword(0, 0, 16'hAA50));
    drain(100);
    compare_out("lost");
    check("lost_seen", LOST_SEEN, 1'b1);
    check("lost_frame", FRAME_CNT, 16'd1);
    send(rword(1, 0, 16'h0)); send(rword(0, 0, 16'h2)); send(rword(0, 0, 16'h0));
    send(rword(0, 0, 16'h0)); send(rword(0, 0, 16'hAA50));
    drain(100);
    compare_out("lost2");
    check("lost_sticky", LOST_SEEN, 1'b1);
    send(rword(1, 0, 16'h0)); send(rword(0, 0, 16'h3)); send(rword(0, 0, 16'h0));
    send(rword(0, 0, 16'h4)); send(rword(0, 0, 16'hD001)); send(rword(0, 0, 16'hD002));
    drain(100);
    ready_pct = 0;
    send(rword(0, 0, 16'hD003));
    for (int i = 0; i < 3; i++) cycle();
    check("pending_valid", OUT_VALID, 1'b1);
    do_reset();
    check_reset("midreset");
    ready_pct = 100;
    send(rword(1, 0, 16'h0)); send(rword(0, 0, 16'h9)); send(rword(0, 0, 16'h0));
    send(rword(0, 0, 16'h1)); send(rword(0, 0, 16'h4242)); send(rword(0, 0, 16'hAA50));
    drain(100);
    compare_out("fresh");
    check("fresh_frame", FRAME_CNT, 16'd1);

    // ERR_CNT saturation: consecutive start words each truncate the previous frame.
    do_reset();
    for (int i = 0; i < 260; i++) send(rword(1, 0, 16'(i)));
    drain(1000);
    compare_out("sat");
    check("sat_err", ERR_CNT, 8'd255);
    model_counters("sat");

    // 100 back-to-back good frames under random back-pressure, including LEN=570 and LEN=0.
    do_reset();
    ready_pct = 50;
    gap_pct   = 10;
    for (int f = 0; f < 100; f++) begin
      len = (f == 0) ? 570 : (f == 1) ? 0 : int'($urandom_range(0, 40));
      send(rword(1, 0, 16'(f)));
      send(rword(0, 0, 16'(f)));
      send(rword(0, 0, 16'h0));
      send(rword(0, 0, 16'(len)));
      for (int d = 0; d < len; d++) begin
        w = $urandom;
        send(rword(0, 0, w[15:0]));
      end
      send(rword(0, 0, 16'hAA50));
    end
    drain(30000);
    compare_out("frames");
    check("frames_cnt", FRAME_CNT, 16'd100);
    model_counters("frames");

    // Random mixed traffic: strays, truncations, bad lengths, bad trailers, lost flags.
    do_reset();
    ready_pct = 60;
    gap_pct   = 20;
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 0) w[15:0] = 16'($urandom_range(0, 6));
      else if ($urandom_range(0, 3) == 0) w[15:0] = 16'hAA50;
      send(rword($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, w[15:0]));
    end
    drain(5000);
    compare_out("mixed");
    model_counters("mixed");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
